button_debounce: RTL and testbench

- Multi-channel push-button debouncer directly upstream of the button PIO.
- Synchronises raw board button pins and normalises their polarity.
- A channel changes its output only after its input has held a new level for a programmable time, so the PIO's rising-edge capture fires once per physical press.
- Also emits one-cycle press/release pulses for local logic, which needs no CPU polling.

---
 rtl/button_debounce.sv | 165 ++++++++++++++++
 tb/tb_button_debounce.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// Multi-channel push-button debouncer: synchronises and polarity-normalises raw
// button pins, accepts a new level only after it has held for DEBOUNCE_TICKS
// prescaler ticks, and emits one-cycle press/release strobes.
module button_debounce #(
    parameter int unsigned WIDTH          = 1,
    parameter int unsigned ACTIVE_LOW     = 1,
    parameter int unsigned PRESCALE       = 50000,
    parameter int unsigned DEBOUNCE_TICKS = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] button_in,
    output logic [WIDTH-1:0] btn_out,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned CW = (DEBOUNCE_TICKS > 2) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);
    localparam logic          INVERT   = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        S_LOW       = 2'd0,
        S_WAIT_HIGH = 2'd1,
        S_HIGH      = 2'd2,
        S_WAIT_LOW  = 2'd3
    } state_t;

    logic [WIDTH-1:0] pin_norm;
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [PW-1:0]    pre_cnt;
    logic             tick_c;

    state_t           state_q [WIDTH];
    state_t           state_d [WIDTH];
    logic [CW-1:0]    cnt_q   [WIDTH];
    logic [CW-1:0]    cnt_d   [WIDTH];

    logic [WIDTH-1:0] press_c;
    logic [WIDTH-1:0] release_c;
    logic [WIDTH-1:0] level_c;

    assign pin_norm = button_in ^ {WIDTH{INVERT}};
    assign tick_c   = (pre_cnt == PRE_LAST);

    // Two-flop synchroniser; reset value reads as released.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pin_norm;
            sync2 <= sync1;
        end
    end

    // Shared free-running prescaler producing the debounce tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
        end else if (tick_c) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    // Per-channel state and qualification counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                state_q[i] <= S_LOW;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Next-state: a bounce back to the old level aborts before any tick is honoured.
    always_comb begin
        for (int i = 0; i < int'(WIDTH); i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                S_LOW: begin
                    if (sync2[i]) begin
                        state_d[i] = S_WAIT_HIGH;
                        cnt_d[i]   = '0;
                    end
                end
                S_WAIT_HIGH: begin
                    if (!sync2[i]) begin
                        state_d[i] = S_LOW;
                    end else if (tick_c) begin
                        if (cnt_q[i] == CNT_LAST) begin
                            state_d[i] = S_HIGH;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CW'(1);
                        end
                    end
                end
                S_HIGH: begin
                    if (!sync2[i]) begin
                        state_d[i] = S_WAIT_LOW;
                        cnt_d[i]   = '0;
                    end
                end
                S_WAIT_LOW: begin
                    if (sync2[i]) begin
                        state_d[i] = S_HIGH;
                    end else if (tick_c) begin
                        if (cnt_q[i] == CNT_LAST) begin
                            state_d[i] = S_LOW;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CW'(1);
                        end
                    end
                end
                default: begin
                    state_d[i] = S_LOW;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Output decode: strobes fire only on an accepted transition.
    always_comb begin
        press_c   = '0;
        release_c = '0;
        level_c   = btn_out;
        for (int i = 0; i < int'(WIDTH); i++) begin
            press_c[i]   = (state_q[i] == S_WAIT_HIGH) && sync2[i] && tick_c
                           && (cnt_q[i] == CNT_LAST);
            release_c[i] = (state_q[i] == S_WAIT_LOW) && !sync2[i] && tick_c
                           && (cnt_q[i] == CNT_LAST);
            if (press_c[i]) begin
                level_c[i] = 1'b1;
            end else if (release_c[i]) begin
                level_c[i] = 1'b0;
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_out       <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
        end else begin
            btn_out       <= level_c;
            press_pulse   <= press_c;
            release_pulse <= release_c;
        end
    end

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce: stimulus pushes expected strobes
// (instance, kind, channel, cycle window); a negedge monitor pops and checks.
module tb_button_debounce;

    typedef struct {
        int dut;
        bit rel;
        int ch;
        int lo;
        int hi;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] pin_a;
    logic [1:0] oa, pa, ra;
    logic       pin_b;
    logic       ob, pb, rb;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    button_debounce #(.WIDTH(2), .ACTIVE_LOW(1), .PRESCALE(1), .DEBOUNCE_TICKS(4)) ua (
        .clk(clk), .reset_n(reset_n), .button_in(pin_a),
        .btn_out(oa), .press_pulse(pa), .release_pulse(ra)
    );

    button_debounce #(.WIDTH(1), .ACTIVE_LOW(1), .PRESCALE(4), .DEBOUNCE_TICKS(3)) ub (
        .clk(clk), .reset_n(reset_n), .button_in(pin_b),
        .btn_out(ob), .press_pulse(pb), .release_pulse(rb)
    );

    task automatic expect_pulse(input int d, input bit rel, input int ch, input int lo, input int hi);
        exp_t e;
        e.dut = d; e.rel = rel; e.ch = ch; e.lo = lo; e.hi = hi;
        sbq.push_back(e);
    endtask

    task automatic check_pulse(input int d, input bit rel, input int ch, input logic lvl);
        exp_t e;
        total++;
        if (sbq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_pulse: got dut=%0d rel=%0d ch=%0d cyc=%0d, required no pulse",
                     d, rel, ch, cyc);
        end else begin
            e = sbq.pop_front();
            if (e.dut != d || e.rel != rel || e.ch != ch || cyc < e.lo || cyc > e.hi
                || lvl != !rel) begin
                bad++;
                $display("FAIL pulse: got dut=%0d rel=%0d ch=%0d cyc=%0d lvl=%0b, required dut=%0d rel=%0d ch=%0d cyc=%0d..%0d lvl=%0b",
                         d, rel, ch, cyc, lvl, e.dut, e.rel, e.ch, e.lo, e.hi, !e.rel);
            end
        end
    endtask

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    // Monitor: every strobe seen must match the head of the scoreboard.
    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (pa[c] === 1'b1) check_pulse(0, 1'b0, c, oa[c]);
            if (ra[c] === 1'b1) check_pulse(0, 1'b1, c, oa[c]);
        end
        if (pb === 1'b1) check_pulse(1, 1'b0, 0, ob);
        if (rb === 1'b1) check_pulse(1, 1'b1, 0, ob);
    end

    initial begin
        reset_n = 1'b0;
        pin_a   = 2'b11;
        pin_b   = 1'b1;

        // Reset with buttons released (pins high)
        repeat (3) @(negedge clk);
        chk("reset_btn_a", oa, 2'b00);
        chk("reset_pulse_a", pa | ra, 2'b00);
        chk("reset_btn_b", {1'b0, ob}, 2'b00);
        reset_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("idle_btn_a", oa, 2'b00);
        chk("idle_btn_b", {1'b0, ob}, 2'b00);

        // Clean press on channel 0: accepted at edge 7
        pin_a[0] = 1'b0;
        expect_pulse(0, 1'b0, 0, cyc + 7, cyc + 7);
        repeat (12) @(negedge clk);
        chk("clean_press", oa, 2'b01);

        // Clean release on channel 0
        pin_a[0] = 1'b1;
        expect_pulse(0, 1'b1, 0, cyc + 7, cyc + 7);
        repeat (12) @(negedge clk);
        chk("clean_release", oa, 2'b00);

        // 3-cycle glitch is rejected
        pin_a[0] = 1'b0;
        repeat (3) @(negedge clk);
        pin_a[0] = 1'b1;
        repeat (12) @(negedge clk);
        chk("glitch", oa, 2'b00);

        // Bounce every 2 cycles for 12 cycles, then settle pressed
        for (int k = 0; k < 6; k++) begin
            pin_a[0] = 1'(k % 2);
            repeat (2) @(negedge clk);
        end
        pin_a[0] = 1'b0;
        expect_pulse(0, 1'b0, 0, cyc + 7, cyc + 7);
        repeat (12) @(negedge clk);
        chk("bounce_press", oa, 2'b01);

        // Channel 1 qualifies independently while channel 0 stays pressed
        pin_a[1] = 1'b0;
        expect_pulse(0, 1'b0, 1, cyc + 7, cyc + 7);
        repeat (12) @(negedge clk);
        chk("ch1_press", oa, 2'b11);
        pin_a[1] = 1'b1;
        expect_pulse(0, 1'b1, 1, cyc + 7, cyc + 7);
        repeat (12) @(negedge clk);
        chk("ch1_release", oa, 2'b01);
        pin_a[0] = 1'b1;
        expect_pulse(0, 1'b1, 0, cyc + 7, cyc + 7);
        repeat (12) @(negedge clk);
        chk("ch0_release", oa, 2'b00);

        // Reset while channel 0 is in S_WAIT_HIGH with cnt=2
        pin_a[0] = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midreset_btn", oa, 2'b00);
        chk("midreset_pulse", pa | ra, 2'b00);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        expect_pulse(0, 1'b0, 0, cyc + 7, cyc + 7);
        repeat (12) @(negedge clk);
        chk("requalify_press", oa, 2'b01);
        pin_a[0] = 1'b1;
        expect_pulse(0, 1'b1, 0, cyc + 7, cyc + 7);
        repeat (12) @(negedge clk);
        chk("requalify_release", oa, 2'b00);

        // Prescaled: an 8-cycle level is rejected
        pin_b = 1'b0;
        repeat (8) @(negedge clk);
        pin_b = 1'b1;
        repeat (20) @(negedge clk);
        chk("pre_short", {1'b0, ob}, 2'b00);

        // Prescaled: held press accepted within 11..15 cycles
        pin_b = 1'b0;
        expect_pulse(1, 1'b0, 0, cyc + 11, cyc + 15);
        repeat (20) @(negedge clk);
        chk("pre_press", {1'b0, ob}, 2'b01);
        pin_b = 1'b1;
        expect_pulse(1, 1'b1, 0, cyc + 11, cyc + 15);
        repeat (20) @(negedge clk);
        chk("pre_release", {1'b0, ob}, 2'b00);

        // Every expected strobe must have been observed
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL missing_pulses: got %0d outstanding, required 0", sbq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
